// File: rtl/hwr_pkg.sv
// Shared output-layer definitions: default widths, the streamer state encoding
// and the ReLU-plus-saturate helper used by every layer that emits scores.
package hwr_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int ACC_W       = 20;
    localparam int OUT_W       = 12;
    localparam int SHIFT       = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } stream_state_e;

    // Arithmetic shift, clamp negatives to zero, saturate to OUT_W bits.
    function automatic logic [OUT_W-1:0] sat_relu(input logic signed [ACC_W-1:0] value,
                                                  input int unsigned shift);
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] sat_max;
        sat_max = ACC_W'((1 << OUT_W) - 1);
        s = value >>> shift;
        if (s[ACC_W-1]) begin
            return '0;
        end
        if (s > sat_max) begin
            return '1;
        end
        return s[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/class_score_streamer_if.sv
// Producer-side bundle of the score streamer: frame request/stall in,
// valid-only beat stream and status out.
interface class_score_streamer_if #(
    parameter int NUM_CLASSES = hwr_pkg::NUM_CLASSES,
    parameter int ACC_W       = hwr_pkg::ACC_W,
    parameter int OUT_W       = hwr_pkg::OUT_W
);
    logic                         load;
    logic [NUM_CLASSES*ACC_W-1:0] scores;
    logic                         hold;
    logic                         valid_out;
    logic [OUT_W-1:0]             data_out;
    logic                         last;
    logic                         busy;
    logic                         load_err;

    modport master (
        output load, scores, hold,
        input  valid_out, data_out, last, busy, load_err
    );

    modport slave (
        input  load, scores, hold,
        output valid_out, data_out, last, busy, load_err
    );
endinterface

// File: rtl/score_saturator.sv
// Combinational score scaler: arithmetic right shift, ReLU clamp, then
// saturation to an unsigned OUT_W-bit value.
module score_saturator #(
    parameter int ACC_W = hwr_pkg::ACC_W,
    parameter int OUT_W = hwr_pkg::OUT_W,
    parameter int SHIFT = hwr_pkg::SHIFT
) (
    input  logic signed [ACC_W-1:0] score,
    output logic        [OUT_W-1:0] result
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << OUT_W) - 1);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = score >>> SHIFT;
        if (shifted[ACC_W-1]) begin
            result = '0;
        end else if (shifted > SAT_MAX) begin
            result = '1;
        end else begin
            result = shifted[OUT_W-1:0];
        end
    end
endmodule

// File: rtl/class_score_streamer.sv
// Captures all class accumulators on load and streams them, scaled and
// saturated, one beat per cycle in class order 0..NUM_CLASSES-1.
module class_score_streamer #(
    parameter int NUM_CLASSES = hwr_pkg::NUM_CLASSES,
    parameter int ACC_W       = hwr_pkg::ACC_W,
    parameter int OUT_W       = hwr_pkg::OUT_W,
    parameter int SHIFT       = hwr_pkg::SHIFT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    class_score_streamer_if.slave bus
);
    import hwr_pkg::*;

    localparam int               IDX_W     = $clog2(NUM_CLASSES + 1);
    localparam logic [0:0]       ST_IDLE   = IDLE;
    localparam logic [0:0]       ST_SEND   = SEND;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] IDX_DRAIN = IDX_W'(NUM_CLASSES);

    logic [0:0]              state_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic signed [ACC_W-1:0] score_bank_reg [NUM_CLASSES];
    logic                    valid_reg;
    logic                    last_reg;
    logic                    load_err_reg;
    logic [OUT_W-1:0]        data_reg;
    logic signed [ACC_W-1:0] sel_score;
    logic [OUT_W-1:0]        sat_score;
    logic                    accept;
    logic                    emit;

    // Class 0 is taken straight from the input on the accepting edge so the
    // first beat leaves one cycle after load; later beats come from the bank.
    // idx parks at NUM_CLASSES for one drain cycle after the last beat, which
    // keeps busy high until the cycle after last and spaces frames apart.
    assign accept    = (state_reg == ST_IDLE) && bus.load;
    assign emit      = !bus.hold && (accept || ((state_reg == ST_SEND) && (idx_reg != IDX_DRAIN)));
    assign sel_score = (state_reg == ST_SEND) ? score_bank_reg[idx_reg] : bus.scores[ACC_W-1:0];

    score_saturator #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_saturator (
        .score  (sel_score),
        .result (sat_score)
    );

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_bank
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    score_bank_reg[gi] <= '0;
                end else if (accept) begin
                    score_bank_reg[gi] <= bus.scores[gi*ACC_W +: ACC_W];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            valid_reg    <= 1'b0;
            last_reg     <= 1'b0;
            data_reg     <= '0;
            load_err_reg <= 1'b0;
        end else begin
            valid_reg <= emit;
            last_reg  <= emit && (idx_reg == IDX_LAST);
            if (emit) begin
                data_reg <= sat_score;
                idx_reg  <= idx_reg + 1'b1;
            end
            if ((state_reg == ST_SEND) && bus.load) begin
                load_err_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (bus.load) begin
                        state_reg <= ST_SEND;
                    end
                end
                default: begin
                    if (!bus.hold && (idx_reg == IDX_DRAIN)) begin
                        state_reg <= ST_IDLE;
                        idx_reg   <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.valid_out = valid_reg;
    assign bus.data_out  = data_reg;
    assign bus.last      = last_reg;
    assign bus.busy      = (state_reg == ST_SEND);
    assign bus.load_err  = load_err_reg;
endmodule
